// File: rtl/rv_pkg.sv
// Shared RV32I constants: ALU operation codes, major opcodes, funct3 values.
// Also provides the funct3 -> ALU operation mapping used by decode.
package rv_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd3,
        ALU_SRL  = 4'd4,
        ALU_SRA  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_SLT  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_XOR  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic alu_op_e f3_op(input logic [2:0] f3,
                                      input logic alt);
        alu_op_e op;
        op = ALU_ADD;
        case (f3)
            F3_ADD:  op = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  op = ALU_SLL;
            F3_SLT:  op = ALU_SLT;
            F3_SLTU: op = ALU_SLTU;
            F3_XOR:  op = ALU_XOR;
            F3_SR:   op = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   op = ALU_OR;
            F3_AND:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// Combinational immediate extraction for I-type and U-type encodings.
// Shared with the branch and load/store stages.
module rv_imm_gen #(
    parameter int W = 32
) (
    input  logic [31:0]  instr,
    output logic [W-1:0] imm_i,
    output logic [W-1:0] imm_u
);

    logic unused_low;

    assign imm_i = W'($signed(instr[31:20]));
    assign imm_u = W'($signed({instr[31:12], 12'b0}));

    assign unused_low = ^instr[11:0];

endmodule

// File: rtl/rv_decode_stage.sv
// RV32I decode stage (OP, OP-IMM, LUI, AUIPC) with a one-entry ID/EX register.
// Define RV_DECODE_FORWARD_EN to add the FWD_* operand bypass inputs.
module rv_decode_stage
    import rv_pkg::*;
#(
    parameter int WORDSIZE = 32,
    parameter int OPSIZE   = 32,
    parameter int REGIDX   = 5
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                IN_VALID,
    output logic                IN_READY,
    input  logic [31:0]         IN_INSTR,
    input  logic [WORDSIZE-1:0] IN_PC,
    output logic [REGIDX-1:0]   RS1_IDX,
    output logic [REGIDX-1:0]   RS2_IDX,
    input  logic [WORDSIZE-1:0] RS1_DATA,
    input  logic [WORDSIZE-1:0] RS2_DATA,
`ifdef RV_DECODE_FORWARD_EN
    input  logic                FWD_VALID,
    input  logic [REGIDX-1:0]   FWD_RD,
    input  logic [WORDSIZE-1:0] FWD_DATA,
`endif
    input  logic                FLUSH,
    output logic                OUT_VALID,
    input  logic                OUT_READY,
    output logic [WORDSIZE-1:0] OUT_A,
    output logic [WORDSIZE-1:0] OUT_B,
    output logic [OPSIZE-1:0]   OUT_OP,
    output logic [REGIDX-1:0]   OUT_RD,
    output logic                OUT_WE,
    output logic [WORDSIZE-1:0] OUT_PC,
    output logic                OUT_ILLEGAL
);

    logic [6:0]          opcode;
    logic [2:0]          f3;
    logic [6:0]          f7;
    logic [REGIDX-1:0]   rd;
    logic [WORDSIZE-1:0] imm_i;
    logic [WORDSIZE-1:0] imm_u;
    logic [WORDSIZE-1:0] rs1_val;
    logic [WORDSIZE-1:0] rs2_val;
    logic [WORDSIZE-1:0] a;
    logic [WORDSIZE-1:0] b;
    alu_op_e             op;
    logic                legal;
    logic                accept;

    assign opcode  = IN_INSTR[6:0];
    assign f3      = IN_INSTR[14:12];
    assign f7      = IN_INSTR[31:25];
    assign rd      = REGIDX'(IN_INSTR[11:7]);
    assign RS1_IDX = REGIDX'(IN_INSTR[19:15]);
    assign RS2_IDX = REGIDX'(IN_INSTR[24:20]);

    assign IN_READY = !OUT_VALID || OUT_READY;
    assign accept   = IN_VALID && IN_READY && !FLUSH;

`ifdef RV_DECODE_FORWARD_EN
    // x0 is never bypassed: its read value is architecturally zero
    assign rs1_val = (FWD_VALID && FWD_RD != '0 && FWD_RD == RS1_IDX)
                   ? FWD_DATA : RS1_DATA;
    assign rs2_val = (FWD_VALID && FWD_RD != '0 && FWD_RD == RS2_IDX)
                   ? FWD_DATA : RS2_DATA;
`else
    assign rs1_val = RS1_DATA;
    assign rs2_val = RS2_DATA;
`endif

    rv_imm_gen #(.W(WORDSIZE)) u_imm (
        .instr (IN_INSTR),
        .imm_i (imm_i),
        .imm_u (imm_u)
    );

    always_comb begin
        legal = 1'b0;
        op    = ALU_ADD;
        a     = '0;
        b     = '0;
        unique case (1'b1)
            (opcode == OPC_OP): begin
                a     = rs1_val;
                b     = rs2_val;
                op    = f3_op(f3, IN_INSTR[30]);
                legal = (f7 == F7_ZERO)
                     || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
                if (f3 == F3_SLL || f3 == F3_SR)
                    b = WORDSIZE'(rs2_val[4:0]);
            end
            (opcode == OPC_OP_IMM): begin
                a     = rs1_val;
                b     = imm_i;
                // bit 30 is immediate data except on right shifts
                op    = f3_op(f3, IN_INSTR[30] && f3 == F3_SR);
                legal = 1'b1;
                if (f3 == F3_SLL) begin
                    legal = (f7 == F7_ZERO);
                    b     = WORDSIZE'(IN_INSTR[24:20]);
                end else if (f3 == F3_SR) begin
                    legal = (f7 == F7_ZERO) || (f7 == F7_ALT);
                    b     = WORDSIZE'(IN_INSTR[24:20]);
                end
            end
            (opcode == OPC_LUI): begin
                a     = WORDSIZE'(IN_INSTR[31:12]);
                b     = '0;
                op    = ALU_LUI;
                legal = 1'b1;
            end
            (opcode == OPC_AUIPC): begin
                a     = IN_PC;
                b     = imm_u;
                op    = ALU_ADD;
                legal = 1'b1;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            op = ALU_ADD;
            a  = '0;
            b  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            OUT_VALID   <= 1'b0;
            OUT_A       <= '0;
            OUT_B       <= '0;
            OUT_OP      <= '0;
            OUT_RD      <= '0;
            OUT_WE      <= 1'b0;
            OUT_PC      <= '0;
            OUT_ILLEGAL <= 1'b0;
        end else if (FLUSH) begin
            OUT_VALID <= 1'b0;
        end else if (accept) begin
            OUT_VALID   <= 1'b1;
            OUT_A       <= a;
            OUT_B       <= b;
            OUT_OP      <= OPSIZE'(op);
            OUT_RD      <= rd;
            OUT_WE      <= legal && (rd != '0);
            OUT_PC      <= IN_PC;
            OUT_ILLEGAL <= !legal;
        end else if (OUT_READY) begin
            OUT_VALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed-vector bench for rv_decode_stage.
// Forwarding vectors are included when RV_DECODE_FORWARD_EN is defined.
module tb_rv_decode_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [31:0] IN_INSTR;
    logic [31:0] IN_PC;
    logic [4:0]  RS1_IDX;
    logic [4:0]  RS2_IDX;
    logic [31:0] RS1_DATA;
    logic [31:0] RS2_DATA;
    logic        FLUSH;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] OUT_A;
    logic [31:0] OUT_B;
    logic [31:0] OUT_OP;
    logic [4:0]  OUT_RD;
    logic        OUT_WE;
    logic [31:0] OUT_PC;
    logic        OUT_ILLEGAL;
`ifdef RV_DECODE_FORWARD_EN
    logic        FWD_VALID;
    logic [4:0]  FWD_RD;
    logic [31:0] FWD_DATA;
`endif

    int errs  = 0;
    int total = 0;

    always #5 CLK = ~CLK;

    rv_decode_stage dut (
        .CLK         (CLK),
        .RST         (RST),
        .IN_VALID    (IN_VALID),
        .IN_READY    (IN_READY),
        .IN_INSTR    (IN_INSTR),
        .IN_PC       (IN_PC),
        .RS1_IDX     (RS1_IDX),
        .RS2_IDX     (RS2_IDX),
        .RS1_DATA    (RS1_DATA),
        .RS2_DATA    (RS2_DATA),
`ifdef RV_DECODE_FORWARD_EN
        .FWD_VALID   (FWD_VALID),
        .FWD_RD      (FWD_RD),
        .FWD_DATA    (FWD_DATA),
`endif
        .FLUSH       (FLUSH),
        .OUT_VALID   (OUT_VALID),
        .OUT_READY   (OUT_READY),
        .OUT_A       (OUT_A),
        .OUT_B       (OUT_B),
        .OUT_OP      (OUT_OP),
        .OUT_RD      (OUT_RD),
        .OUT_WE      (OUT_WE),
        .OUT_PC      (OUT_PC),
        .OUT_ILLEGAL (OUT_ILLEGAL)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        IN_VALID = 1'b1;
        IN_INSTR = ins;
        IN_PC    = pc;
        RS1_DATA = r1;
        RS2_DATA = r2;
        tick();
    endtask

    task automatic chk_out(input string tag, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] op,
                           input logic [31:0] rd, input logic we,
                           input logic ill);
        chk({tag, ".valid"}, 32'(OUT_VALID), 32'd1);
        chk({tag, ".a"}, OUT_A, a);
        chk({tag, ".b"}, OUT_B, b);
        chk({tag, ".op"}, OUT_OP, op);
        chk({tag, ".rd"}, 32'(OUT_RD), rd);
        chk({tag, ".we"}, 32'(OUT_WE), 32'(we));
        chk({tag, ".ill"}, 32'(OUT_ILLEGAL), 32'(ill));
    endtask

    initial begin
        RST = 1'b1; IN_VALID = 1'b0; IN_INSTR = '0; IN_PC = '0;
        RS1_DATA = '0; RS2_DATA = '0; FLUSH = 1'b0; OUT_READY = 1'b1;
`ifdef RV_DECODE_FORWARD_EN
        FWD_VALID = 1'b0; FWD_RD = '0; FWD_DATA = '0;
`endif
        tick();
        tick();
        chk("rst.valid", 32'(OUT_VALID), 32'd0);
        chk("rst.a", OUT_A, 32'd0);
        chk("rst.op", OUT_OP, 32'd0);
        chk("rst.we", 32'(OUT_WE), 32'd0);
        chk("rst.in_ready", 32'(IN_READY), 32'd1);
        RST = 1'b0;

        // ADD x3,x1,x2
        IN_INSTR = 32'h002081B3;
        #1;
        chk("add.rs1_idx", 32'(RS1_IDX), 32'd1);
        chk("add.rs2_idx", 32'(RS2_IDX), 32'd2);
        issue(32'h002081B3, 32'h100, 32'd5, 32'd7);
        chk_out("add", 32'd5, 32'd7, 32'd0, 32'd3, 1'b1, 1'b0);
        chk("add.pc", OUT_PC, 32'h100);

        issue(32'h402081B3, 32'h104, 32'd9, 32'd4);
        chk_out("sub", 32'd9, 32'd4, 32'd1, 32'd3, 1'b1, 1'b0);

        issue(32'h40335293, 32'h108, 32'hF000_0000, 32'd0);
        chk_out("srai", 32'hF000_0000, 32'd3, 32'd5, 32'd5, 1'b1, 1'b0);

        issue(32'h00335293, 32'h10C, 32'hF000_0000, 32'd0);
        chk_out("srli", 32'hF000_0000, 32'd3, 32'd4, 32'd5, 1'b1, 1'b0);

        // SLTIU x1,x2,-1
        issue(32'hFFF13093, 32'h110, 32'd1, 32'd0);
        chk_out("sltiu", 32'd1, 32'hFFFF_FFFF, 32'd6, 32'd1, 1'b1, 1'b0);

        // SLLI with funct7=0100000 is not a legal encoding
        issue(32'h40331293, 32'h114, 32'd1, 32'd0);
        chk_out("slli_bad", 32'd0, 32'd0, 32'd0, 32'd5, 1'b0, 1'b1);

        // SLL x3,x1,x2 uses only the low 5 bits of rs2
        issue(32'h002091B3, 32'h118, 32'd1, 32'h123);
        chk_out("sll", 32'd1, 32'd3, 32'd3, 32'd3, 1'b1, 1'b0);

        issue(32'h123450B7, 32'h11C, 32'hDEAD, 32'hBEEF);
        chk_out("lui", 32'h0001_2345, 32'd0, 32'd11, 32'd1, 1'b1, 1'b0);

        // AUIPC x2,0xFFFFF
        issue(32'hFFFFF117, 32'h200, 32'd0, 32'd0);
        chk_out("auipc", 32'h200, 32'hFFFF_F000, 32'd0, 32'd2, 1'b1, 1'b0);

        issue(32'h00000013, 32'h204, 32'd0, 32'd0);
        chk_out("addi_x0", 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);

        issue(32'h00000000, 32'h208, 32'd3, 32'd4);
        chk_out("zero_word", 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b1);

        // backpressure
        issue(32'h002081B3, 32'h300, 32'd5, 32'd7);
        chk("bp.first_pc", OUT_PC, 32'h300);
        OUT_READY = 1'b0;
        IN_VALID = 1'b1; IN_INSTR = 32'h402081B3; IN_PC = 32'h304;
        RS1_DATA = 32'd9; RS2_DATA = 32'd4;
        #1;
        chk("bp.in_ready", 32'(IN_READY), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp.hold_valid", 32'(OUT_VALID), 32'd1);
            chk("bp.hold_a", OUT_A, 32'd5);
            chk("bp.hold_pc", OUT_PC, 32'h300);
            chk("bp.hold_ready", 32'(IN_READY), 32'd0);
        end
        OUT_READY = 1'b1;
        #1;
        chk("bp.release_ready", 32'(IN_READY), 32'd1);
        tick();
        chk_out("bp.second", 32'd9, 32'd4, 32'd1, 32'd3, 1'b1, 1'b0);
        chk("bp.second_pc", OUT_PC, 32'h304);
        IN_VALID = 1'b0;
        tick();
        chk("drain.valid", 32'(OUT_VALID), 32'd0);

        // flush beats a same-cycle accept
        FLUSH = 1'b1;
        issue(32'h002081B3, 32'h400, 32'd5, 32'd7);
        chk("flush_in.valid", 32'(OUT_VALID), 32'd0);
        FLUSH = 1'b0;
        issue(32'h002081B3, 32'h404, 32'd5, 32'd7);
        chk("flush_load.valid", 32'(OUT_VALID), 32'd1);
        OUT_READY = 1'b0; IN_VALID = 1'b0; FLUSH = 1'b1;
        tick();
        chk("flush_reg.valid", 32'(OUT_VALID), 32'd0);
        FLUSH = 1'b0; OUT_READY = 1'b1;

        // reset during a stall
        issue(32'h123450B7, 32'h500, 32'd0, 32'd0);
        OUT_READY = 1'b0;
        issue(32'h002081B3, 32'h504, 32'd5, 32'd7);
        chk("stall.a", OUT_A, 32'h0001_2345);
        RST = 1'b1;
        tick();
        chk("rst2.valid", 32'(OUT_VALID), 32'd0);
        chk("rst2.a", OUT_A, 32'd0);
        chk("rst2.op", OUT_OP, 32'd0);
        chk("rst2.rd", 32'(OUT_RD), 32'd0);
        chk("rst2.pc", OUT_PC, 32'd0);
        chk("rst2.we", 32'(OUT_WE), 32'd0);
        RST = 1'b0; OUT_READY = 1'b1; IN_VALID = 1'b0;
        tick();

`ifdef RV_DECODE_FORWARD_EN
        FWD_VALID = 1'b1; FWD_RD = 5'd1; FWD_DATA = 32'h55;
        issue(32'h002081B3, 32'h600, 32'd5, 32'd7);
        chk_out("fwd_rs1", 32'h55, 32'd7, 32'd0, 32'd3, 1'b1, 1'b0);
        FWD_RD = 5'd2;
        issue(32'h002081B3, 32'h604, 32'd5, 32'd7);
        chk_out("fwd_rs2", 32'd5, 32'h55, 32'd0, 32'd3, 1'b1, 1'b0);
        FWD_RD = 5'd0;
        issue(32'h002081B3, 32'h608, 32'd5, 32'd7);
        chk_out("fwd_x0", 32'd5, 32'd7, 32'd0, 32'd3, 1'b1, 1'b0);
        FWD_VALID = 1'b0;
        IN_VALID = 1'b0;
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errs, total);
        $finish;
    end

endmodule
